// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet transmitter.
//   - state_e    : transmitter FSM states
//   - header layout: {len[5:0], dest[1:0]}
//   - MAX_LEN    : largest legal payload length, which sets the buffer depth
//   - DEST_ILLEGAL : destination code the router does not implement
//   - helpers to build a header byte and to classify a command
// -----------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  // Header byte field positions.
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int DEST_MSB = 1;

  localparam int MAX_LEN   = 63;
  localparam int BUF_DEPTH = MAX_LEN + 1;
  localparam int IDX_W     = 6;

  localparam logic [1:0] DEST_ILLEGAL = 2'b11;

  function automatic logic [7:0] make_header(input logic [IDX_W-1:0] len,
                                             input logic [1:0]       dest);
    logic [7:0] hdr;
    hdr                   = '0;
    hdr[LEN_MSB:LEN_LSB]  = len;
    hdr[DEST_MSB:0]       = dest;
    return hdr;
  endfunction

  function automatic logic cmd_legal(input logic [1:0]       dest,
                                     input logic [IDX_W-1:0] len);
    return (dest != DEST_ILLEGAL) && (len != '0);
  endfunction

endpackage

// File: rtl/pkt_buf.sv
// -----------------------------------------------------------------------------
// pkt_buf
// Payload buffer for one packet: BUF_DEPTH x 8 register file with a
// synchronous write port and an asynchronous (combinational) read port.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write byte
//   raddr_i  : read index
//   rdata_o  : byte stored at raddr_i (same cycle)
// -----------------------------------------------------------------------------
module pkt_buf
  import router_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [BUF_DEPTH];

  // NOTE: the storage array has no reset; every entry a packet reads is
  // written during that packet's LOAD phase first, so stale contents after
  // reset are never observed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet transmitter driving the router input port. A command (dest, len)
// is accepted, len payload bytes are buffered from a valid/ready stream,
// then header, payload and parity bytes are sent back-to-back under the
// router's busy back-pressure, followed by GAP_CYCLES idle cycles.
// Parameters:
//   GAP_CYCLES     : idle cycles forced between packets (0..15)
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_dest, cmd_len, inject_par_err : command interface
//   pl_valid/ready, pl_data                            : payload stream
//   busy           : router stall; presented byte held while high
//   pkt_valid      : high for header/payload bytes, low for parity
//   data_out       : byte to the router
//   tx_done        : one-cycle pulse after the parity byte is taken
//   cmd_err        : one-cycle pulse after an illegal command is consumed
// -----------------------------------------------------------------------------
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [5:0] cmd_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_done,
  output logic       cmd_err,
  input  logic       inject_par_err
);

  import router_pkg::*;

  // Last value of the gap counter; unused when GAP_CYCLES is 0.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] len_q;
  logic [1:0]       dest_q;
  logic             inj_q;
  logic [7:0]       parity_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [3:0]       gap_cnt_q;

  logic             pkt_valid_q;
  logic [7:0]       data_q;
  logic             tx_done_q;
  logic             cmd_err_q;

  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic [7:0]       hdr_d;
  logic [7:0]       cmd_hdr_d;
  logic [7:0]       par_byte_d;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign pl_ready   = (state_q == ST_LOAD);
  assign buf_we     = pl_ready && pl_valid;

  assign hdr_d      = make_header(len_q, dest_q);
  assign cmd_hdr_d  = make_header(cmd_len, cmd_dest);
  assign par_byte_d = parity_q ^ {8{inj_q}};

  pkt_buf u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (pl_data),
    .raddr_i (rd_idx_q),
    .rdata_o (buf_rdata)
  );

  // The output register always holds the byte currently offered to the
  // router. On an accepted edge (!busy) it is reloaded with the next byte,
  // so the router side never sees a bubble between header and parity.
  // rd_idx_q is the index of the next payload byte to load; it reaches len
  // exactly when the last payload byte is on the wire (no 6-bit wrap).
  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every term on the right-hand side is the value from before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      dest_q      <= '0;
      inj_q       <= 1'b0;
      parity_q    <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      gap_cnt_q   <= '0;
      pkt_valid_q <= 1'b0;
      data_q      <= '0;
      tx_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      // Pulses default low and are raised for a single cycle below.
      tx_done_q <= 1'b0;
      cmd_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_legal(cmd_dest, cmd_len)) begin
              len_q    <= cmd_len;
              dest_q   <= cmd_dest;
              inj_q    <= inject_par_err;
              parity_q <= cmd_hdr_d;
              wr_idx_q <= '0;
              state_q  <= ST_LOAD;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (pl_valid) begin
            parity_q <= parity_q ^ pl_data;
            wr_idx_q <= wr_idx_q + 6'd1;
            if (wr_idx_q == len_q - 6'd1) begin
              data_q      <= hdr_d;
              pkt_valid_q <= 1'b1;
              rd_idx_q    <= '0;
              state_q     <= ST_HEADER;
            end
          end
        end

        ST_HEADER: begin
          if (!busy) begin
            data_q   <= buf_rdata;
            rd_idx_q <= rd_idx_q + 6'd1;
            state_q  <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (!busy) begin
            if (rd_idx_q == len_q) begin
              data_q      <= par_byte_d;
              pkt_valid_q <= 1'b0;
              state_q     <= ST_PARITY;
            end else begin
              data_q   <= buf_rdata;
              rd_idx_q <= rd_idx_q + 6'd1;
            end
          end
        end

        ST_PARITY: begin
          if (!busy) begin
            tx_done_q <= 1'b1;
            data_q    <= '0;
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_q;
  assign tx_done   = tx_done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed bench for router_pkt_tx: a table of packet records with
// hand-computed header/parity bytes, plus hand-written sequences for reset,
// illegal commands, parity stall, mid-packet reset and back-to-back gaps.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;

  localparam int GAP = 2;
  localparam int NV  = 8;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic [5:0] cmd_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       cmd_err;
  logic       inject_par_err;

  int n_run  = 0;
  int n_fail = 0;
  int post_done = 0;

  // busy_mode: 0 never, 1 random, 2 alternating, 3 five stall cycles on parity
  typedef struct {
    logic [1:0] dest;
    logic [5:0] len;
    logic       inj;
    logic [7:0] base;
    logic [7:0] step;
    logic       bubbles;
    int         busy_mode;
    int         abort_after;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
    logic       chk_gap;
  } vec_t;

  vec_t vecs [NV];

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dest       (cmd_dest),
    .cmd_len        (cmd_len),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .pl_data        (pl_data),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_out       (data_out),
    .tx_done        (tx_done),
    .cmd_err        (cmd_err),
    .inject_par_err (inject_par_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  task automatic check(input int id, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] dest, input logic [5:0] len,
                              input logic inj, input logic [7:0] base,
                              input logic [7:0] step, input logic bubbles,
                              input int mode, input int abort_after,
                              input logic [7:0] hdr, input logic [7:0] par,
                              input logic chk_gap);
    vec_t v;
    v.dest = dest; v.len = len; v.inj = inj; v.base = base; v.step = step;
    v.bubbles = bubbles; v.busy_mode = mode; v.abort_after = abort_after;
    v.exp_hdr = hdr; v.exp_par = par; v.chk_gap = chk_gap;
    return v;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic run_pkt(input int id, input vec_t v);
    int         waited;
    int         i;
    int         cyc;
    int         acc;
    int         stalls;
    int         par_stall;
    logic       bz;
    logic [7:0] exp_b;
    logic       exp_v;
    logic [7:0] held_d;
    logic       held_v;

    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    check(id, "cmd_ready_wait", 32'(cmd_ready), 32'd1);
    if (v.chk_gap) check(id, "gap_cycles", 32'(post_done + waited), 32'(GAP));

    cmd_valid = 1'b1; cmd_dest = v.dest; cmd_len = v.len; inject_par_err = v.inj;
    @(posedge clock); #1;
    cmd_valid = 1'b0; inject_par_err = 1'b0;
    check(id, "pl_ready_up", 32'(pl_ready), 32'd1);

    i = 0; cyc = 0;
    while (i < int'(v.len) && cyc < 400) begin
      pl_valid = !(v.bubbles && (cyc % 3 == 2));
      pl_data  = v.base + 8'(i) * v.step;
      @(posedge clock); #1;
      if (pl_valid) i++;
      cyc++;
    end
    pl_valid = 1'b0;
    check(id, "load_count", 32'(i), 32'(v.len));
    check(id, "hdr_timing_valid", 32'(pkt_valid), 32'd1);
    check(id, "hdr_timing_data", 32'(data_out), 32'(v.exp_hdr));
    check(id, "pl_ready_down", 32'(pl_ready), 32'd0);

    acc = 0; cyc = 0; stalls = 0; par_stall = 0;
    while (acc < int'(v.len) + 2 && cyc < 1000) begin
      if (v.abort_after != 0 && acc == v.abort_after) begin
        reset = 1'b1; #1;
        check(id, "rst_mid_valid", 32'(pkt_valid), 32'd0);
        check(id, "rst_mid_data", 32'(data_out), 32'd0);
        check(id, "rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0; busy = 1'b0; post_done = 0;
        return;
      end
      case (v.busy_mode)
        1:       bz = 1'($urandom_range(0, 1));
        2:       bz = (cyc % 2 == 1);
        3:       bz = (acc == int'(v.len) + 1) && (par_stall < 5);
        default: bz = 1'b0;
      endcase
      busy = bz;
      if (!bz) begin
        if (acc == 0) begin
          exp_b = v.exp_hdr; exp_v = 1'b1;
        end else if (acc <= int'(v.len)) begin
          exp_b = v.base + 8'(acc - 1) * v.step; exp_v = 1'b1;
        end else begin
          exp_b = v.exp_par; exp_v = 1'b0;
        end
        check(id, $sformatf("byte%0d_data", acc), 32'(data_out), 32'(exp_b));
        check(id, $sformatf("byte%0d_valid", acc), 32'(pkt_valid), 32'(exp_v));
        acc++;
      end else begin
        stalls++;
        if (acc == int'(v.len) + 1) par_stall++;
      end
      held_d = data_out;
      held_v = pkt_valid;
      @(posedge clock); #1;
      cyc++;
      if (bz) begin
        check(id, "hold_data", 32'(data_out), 32'(held_d));
        check(id, "hold_valid", 32'(pkt_valid), 32'(held_v));
        check(id, "tx_done_in_stall", 32'(tx_done), 32'd0);
      end
    end
    busy = 1'b0;
    check(id, "accepted_bytes", 32'(acc), 32'(int'(v.len) + 2));
    check(id, "router_cycles", 32'(cyc), 32'(int'(v.len) + 2 + stalls));
    check(id, "tx_done_high", 32'(tx_done), 32'd1);
    @(posedge clock); #1;
    check(id, "tx_done_pulse", 32'(tx_done), 32'd0);
    check(id, "post_valid", 32'(pkt_valid), 32'd0);
    post_done = 1;
  endtask

  task automatic illegal_cmd(input int id, input logic [1:0] dest, input logic [5:0] len);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    check(id, "cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_dest = dest; cmd_len = len;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check(id, "cmd_err_pulse", 32'(cmd_err), 32'd1);
    check(id, "stay_idle", 32'(cmd_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check(id, "pl_ready_low", 32'(pl_ready), 32'd0);
      check(id, "no_traffic", 32'(pkt_valid), 32'd0);
      @(posedge clock); #1;
      check(id, "cmd_err_cleared", 32'(cmd_err), 32'd0);
    end
  endtask

  initial begin
    // Payload byte i = base + i*step; header = {len, dest}; parity = XOR of
    // header and payload, inverted when inj is set.
    vecs[0] = mk(2'd0, 6'd1,  1'b0, 8'hA5, 8'h00, 1'b0, 0, 0,  8'h04, 8'hA1, 1'b0);
    vecs[1] = mk(2'd2, 6'd63, 1'b0, 8'h00, 8'h01, 1'b1, 1, 0,  8'hFE, 8'hC1, 1'b0);
    vecs[2] = mk(2'd1, 6'd2,  1'b0, 8'h10, 8'h01, 1'b0, 0, 0,  8'h09, 8'h08, 1'b0);
    vecs[3] = mk(2'd0, 6'd3,  1'b0, 8'hFF, 8'h00, 1'b0, 3, 0,  8'h0C, 8'hF3, 1'b0);
    vecs[4] = mk(2'd1, 6'd20, 1'b0, 8'h30, 8'h01, 1'b0, 0, 11, 8'h51, 8'h00, 1'b0);
    vecs[5] = mk(2'd2, 6'd4,  1'b0, 8'h01, 8'h02, 1'b1, 2, 0,  8'h12, 8'h12, 1'b0);
    vecs[6] = mk(2'd0, 6'd2,  1'b0, 8'h55, 8'h11, 1'b0, 0, 0,  8'h08, 8'h3B, 1'b0);
    vecs[7] = mk(2'd1, 6'd1,  1'b1, 8'h3C, 8'h00, 1'b0, 0, 0,  8'h05, 8'hC6, 1'b1);

    reset = 1'b1; cmd_valid = 1'b0; cmd_dest = '0; cmd_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; inject_par_err = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check(0, "rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check(0, "rst_pl_ready", 32'(pl_ready), 32'd0);
    check(0, "rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check(0, "rst_data_out", 32'(data_out), 32'd0);
    check(0, "rst_tx_done", 32'(tx_done), 32'd0);
    check(0, "rst_cmd_err", 32'(cmd_err), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    illegal_cmd(100, 2'd3, 6'd5);
    illegal_cmd(101, 2'd0, 6'd0);

    for (int k = 0; k < NV; k++) begin
      run_pkt(k, vecs[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
